chan_scan_mux: RTL and testbench
================================

Name: chan_scan_mux

Overview:
- Parametrised successor to the fixed 6-input selector used in the PmodACL2 wrapper.
- Two operating modes:
  - Mode 1 (direct): registered N-to-1 select.
  - Mode 0 (scan): snapshots all channels on a start strobe, then streams them out one per beat, lowest index first, over a valid/ready handshake.
- Sits between the accelerometer axis/temperature registers and the UART/BLE packetiser.

Parameters:
- WIDTH, 12: bits per channel.
- NUM_CH, 6: channel count, 1..16.
- SEL_W, 3: select/index width. Must satisfy 2**SEL_W >= NUM_CH and SEL_W >= 1.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- din  in  NUM_CH*WIDTH  packed channels; channel k is din[k*WIDTH +: WIDTH].
- mode  in  1  0 = scan, 1 = direct. Sampled only in IDLE.
- sel  in  SEL_W  channel select for direct mode.
- start  in  1  scan trigger pulse.
- out_data  out  WIDTH  selected or streamed sample.
- out_chan  out  SEL_W  index of the sample on out_data.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts the beat.
- out_last  out  1  final beat of a scan.
- busy  out  1  a scan is in progress.
- overrun  out  1  sticky flag: start arrived while busy.
- ch_mask  in  NUM_CH  channel enable mask. Present only with CH_MASK_EN.

Behaviour:
- Reset (synchronous, active-high): state = IDLE. out_data, out_chan, out_valid, out_last, busy and overrun all 0. The snapshot register is not required to reset.
- States: IDLE, DIRECT, SCAN.
- IDLE:
  - mode=1 -> DIRECT next cycle.
  - mode=0 and start=1 -> capture snapshot <= din, idx <= first channel, go to SCAN. busy=1 and out_valid=1 on the next cycle.
- DIRECT:
  - Each cycle: out_data <= din[sel], out_chan <= sel, out_valid <= 1. Latency is 1 cycle from sel/din to output.
  - sel >= NUM_CH -> out_data <= 0, out_chan <= sel, out_valid <= 1.
  - out_ready is ignored.
  - mode=0 -> next cycle state = IDLE, out_valid = 0.
  - start is ignored in DIRECT and does not set overrun.
- SCAN:
  - out_data = snapshot[idx], out_chan = idx, out_last = (idx is the final channel).
  - Beat accepted when out_valid && out_ready. Without acceptance, out_data, out_chan and out_last hold stable.
  - Accepted, not last: idx advances to the next channel the following cycle. No bubble: sustained ready gives 1 beat per cycle.
  - Accepted, last: next cycle state = IDLE with out_valid, out_last and busy all 0.
  - mode changes during SCAN are ignored until IDLE.
  - start while busy: ignored, overrun <= 1. This includes the same cycle as the last accept; no back-to-back chaining.
- overrun: cleared only by rst.
- NUM_CH=1: a scan is a single beat with out_last=1.
- Snapshot isolation: din changes during SCAN do not affect the streamed data.
- rst mid-scan: abandon immediately. Cycle after rst: all outputs 0, state IDLE. The first start after rst begins a fresh scan.

Optional Feature:
- Macro: CH_MASK_EN.
- Defined:
  - The ch_mask port exists and is sampled with the snapshot at start.
  - SCAN visits only channels whose mask bit is 1, ascending. out_last marks the highest enabled channel.
  - Mask all-zero at start: no scan begins, busy stays 0, overrun unaffected.
  - DIRECT mode ignores the mask.
- Undefined: no ch_mask port; all NUM_CH channels are scanned.

Decomposition:
- Package chan_scan_pkg holds:
  - state encoding typedef (IDLE=2'd0, DIRECT=2'd1, SCAN=2'd2);
  - default WIDTH and NUM_CH constants;
  - a next_enabled(mask, idx) function, used under CH_MASK_EN.
- Natural sub-module: chan_scan_next_idx. It is combinational: given mask and current idx, it returns the next enabled index and an is_last flag. It is unit-testable on its own.

Test Plan:
- Direct select (rst, mode=1, NUM_CH=6, din ch0..5 = 0x101..0x106):
  - sel=3 -> one cycle later out_data=0x104, out_chan=3, out_valid=1.
  - sel=7 -> out_data=0.
- Full scan (mode=0, start pulse, out_ready=1) -> six consecutive beats 0x101..0x106, out_chan 0..5, out_last only on beat 5, busy drops the cycle after.
- Backpressure: out_ready low for 3 cycles on beat 2 -> out_data=0x103 held stable for 3 cycles. Change din mid-scan -> streamed values unchanged.
- Start while busy: second start during beat 1 -> overrun=1 and remains 1 after the scan. Exactly 6 beats delivered.
- Reset mid-scan: rst asserted on beat 3 -> next cycle out_valid=0, busy=0, overrun=0. A new start yields beats beginning at ch0.
- CH_MASK_EN:
  - ch_mask=6'b100101 -> beats ch0, ch2, ch5, with out_last on ch5.
  - ch_mask=0 -> no beat, busy stays 0.

Source files
------------

// File: rtl/chan_scan_pkg.sv
// Shared definitions for the channel scan multiplexer: FSM state encoding,
// default geometry, and the enabled-channel search used to step through a scan.
package chan_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIRECT = 2'd1,
        ST_SCAN   = 2'd2
    } state_t;

    localparam int DEF_WIDTH  = 12;
    localparam int DEF_NUM_CH = 6;
    localparam int MAX_CH     = 16;

    // Returned by next_enabled when no enabled channel remains.
    localparam logic [4:0] NO_CH = 5'd16;

    // Lowest channel k >= idx whose mask bit is set, or NO_CH if none.
    function automatic logic [4:0] next_enabled(input logic [15:0] mask,
                                                input logic [4:0]  idx);
        logic [4:0] res;
        res = NO_CH;
        for (int k = MAX_CH - 1; k >= 0; k--) begin
            if (mask[k] && (5'(k) >= idx)) begin
                res = 5'(k);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/chan_scan_next_idx.sv
// Combinational scan stepper: given the channel enable mask and the channel
// currently on the output, returns the next enabled channel and whether the
// current channel is the final one of the scan.
module chan_scan_next_idx
    import chan_scan_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int SEL_W  = 3
) (
    input  logic [NUM_CH-1:0] mask,
    input  logic [SEL_W-1:0]  idx,
    output logic [SEL_W-1:0]  next_idx,
    output logic              is_last
);

    logic [15:0] mask_ext;
    logic [4:0]  idx_ext;
    logic [4:0]  nxt;

    assign mask_ext = 16'(mask);
    assign idx_ext  = 5'(idx);
    assign nxt      = next_enabled(mask_ext, idx_ext + 5'd1);

    // next_idx is only meaningful when is_last is low.
    assign next_idx = SEL_W'(nxt);
    assign is_last  = (nxt == NO_CH);

endmodule

// File: rtl/chan_scan_mux.sv
// Channel scan multiplexer. Direct mode is a registered N-to-1 select; scan
// mode snapshots all channels on start and streams them out lowest index
// first over a valid/ready handshake.
// Optional build macro CH_MASK_EN adds the ch_mask input, which restricts a
// scan to the enabled channels (mask captured together with the snapshot).
module chan_scan_mux
    import chan_scan_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int SEL_W  = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH*WIDTH-1:0] din,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    start,
`ifdef CH_MASK_EN
    input  logic [NUM_CH-1:0]       ch_mask,
`endif
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_chan,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_last,
    output logic                    busy,
    output logic                    overrun
);

    state_t            state_q;
    state_t            state_d;
    logic [WIDTH-1:0]  chan [NUM_CH];
    logic [WIDTH-1:0]  snap [NUM_CH];
    logic [NUM_CH-1:0] mask_in;
    logic [NUM_CH-1:0] mask_q;
    logic [SEL_W-1:0]  first_idx;
    logic [SEL_W-1:0]  nxt_idx;
    logic              cur_last;
    logic              mask_any;
    logic              scan_go;
    logic              accept;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
        assign chan[g] = din[g*WIDTH +: WIDTH];
    end

`ifdef CH_MASK_EN
    assign mask_in = ch_mask;
`else
    assign mask_in = '1;
    assign mask_q  = '1;
`endif

    assign first_idx = SEL_W'(next_enabled(16'(mask_in), 5'd0));
    assign mask_any  = |mask_in;

    // Stepping is always relative to the channel currently presented.
    chan_scan_next_idx #(
        .NUM_CH (NUM_CH),
        .SEL_W  (SEL_W)
    ) u_next (
        .mask     (mask_q),
        .idx      (out_chan),
        .next_idx (nxt_idx),
        .is_last  (cur_last)
    );

    assign busy     = (state_q == ST_SCAN);
    assign out_last = busy && cur_last;
    assign accept   = busy && out_valid && out_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; mode and start only matter while idle.
    always_comb begin
        state_d = state_q;
        scan_go = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mode) begin
                    state_d = ST_DIRECT;
                end else if (start && mask_any) begin
                    state_d = ST_SCAN;
                    scan_go = 1'b1;
                end
            end
            ST_DIRECT: begin
                if (!mode) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (accept && cur_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Snapshot of all channels (and the mask) taken as a scan starts.
    always_ff @(posedge clk) begin
        if (scan_go) begin
            for (int k = 0; k < NUM_CH; k++) begin
                snap[k] <= chan[k];
            end
`ifdef CH_MASK_EN
            mask_q <= mask_in;
`endif
        end
    end

    // Output beat register and sticky overrun flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data  <= '0;
            out_chan  <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (busy && start) begin
                overrun <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    out_valid <= scan_go;
                    if (scan_go) begin
                        out_data <= chan[first_idx];
                        out_chan <= first_idx;
                    end
                end
                ST_DIRECT: begin
                    out_valid <= mode;
                    if (mode) begin
                        out_data <= (int'(sel) < NUM_CH) ? chan[sel] : '0;
                        out_chan <= sel;
                    end
                end
                ST_SCAN: begin
                    if (accept) begin
                        out_valid <= !cur_last;
                        if (!cur_last) begin
                            out_data <= snap[nxt_idx];
                            out_chan <= nxt_idx;
                        end
                    end
                end
                default: out_valid <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_chan_scan_mux.sv
// Bench for chan_scan_mux: random direct-select and scan traffic, expected
// beats queued from a channel-list model, checked by an independent monitor.
module tb_chan_scan_mux;

    localparam int WIDTH  = 12;
    localparam int NUM_CH = 6;
    localparam int SEL_W  = 3;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [SEL_W-1:0] chan;
        logic             last;
    } beat_t;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NUM_CH*WIDTH-1:0] din;
    logic                    mode;
    logic [SEL_W-1:0]        sel;
    logic                    start;
    logic [NUM_CH-1:0]       mask_m;
    logic [WIDTH-1:0]        out_data;
    logic [SEL_W-1:0]        out_chan;
    logic                    out_valid;
    logic                    out_ready;
    logic                    out_last;
    logic                    busy;
    logic                    overrun;

    beat_t sb[$];
    int    total  = 0;
    int    passed = 0;
    bit    bp_en = 0;
    bit    scram_en = 0;
    bit    exp_overrun = 0;
    bit    expect_idle = 0;
    bit    hold_chk = 0;
    beat_t prev;

    chan_scan_mux #(
        .WIDTH  (WIDTH),
        .NUM_CH (NUM_CH),
        .SEL_W  (SEL_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .mode      (mode),
        .sel       (sel),
        .start     (start),
`ifdef CH_MASK_EN
        .ch_mask   (mask_m),
`endif
        .out_data  (out_data),
        .out_chan  (out_chan),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [NUM_CH*WIDTH-1:0] rand_din();
        logic [NUM_CH*WIDTH-1:0] r;
        for (int k = 0; k < NUM_CH; k++) r[k*WIDTH +: WIDTH] = WIDTH'($urandom);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        if (scram_en) din = rand_din();
    endtask

    // Model: a scan is the list of enabled channels in ascending order, the
    // highest one flagged last, values taken from din at the start strobe.
    task automatic push_scan();
        int    hi;
        beat_t b;
        hi = -1;
        for (int k = 0; k < NUM_CH; k++) if (mask_m[k]) hi = k;
        for (int k = 0; k < NUM_CH; k++) begin
            if (mask_m[k]) begin
                b.data = din[k*WIDTH +: WIDTH];
                b.chan = SEL_W'(k);
                b.last = (k == hi);
                sb.push_back(b);
            end
        end
    endtask

    task automatic run_scan(input bit extra, input bit bp, input bit scram);
        int n;
        push_scan();
        bp_en = bp;
        scram_en = scram;
        mode = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        if (extra) begin
            start = 1'b1;
            exp_overrun = 1'b1;
            tick();
            start = 1'b0;
        end
        n = 0;
        while (busy && n < 300) begin
            tick();
            n++;
        end
        bp_en = 0;
        scram_en = 0;
        chk("scan_done_busy", 32'(busy), 0);
        tick();
        chk("sb_drained", sb.size(), 0);
        chk("idle_valid", 32'(out_valid), 0);
        chk("overrun", 32'(overrun), 32'(exp_overrun));
        sb.delete();
    endtask

    task automatic run_direct(input bit rnd);
        int    sels[8];
        beat_t b;
        sels = '{3, 7, 0, 5, 6, 1, 2, 4};
        mode = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            if (rnd) begin
                din = rand_din();
                sel = SEL_W'($urandom);
                start = 1'($urandom_range(0, 1));
            end else begin
                sel = SEL_W'(sels[i]);
            end
            b.data = (int'(sel) < NUM_CH) ? din[int'(sel)*WIDTH +: WIDTH] : '0;
            b.chan = sel;
            b.last = 1'b0;
            sb.push_back(b);
            tick();
        end
        start = 1'b0;
        mode = 1'b0;
        tick();
        tick();
        chk("direct_exit_valid", 32'(out_valid), 0);
        chk("direct_sb_drained", sb.size(), 0);
        chk("direct_overrun", 32'(overrun), 32'(exp_overrun));
        sb.delete();
    endtask

    // Monitor: pops one expected beat per presented beat, checks hold under
    // backpressure and that the scan closes right after its last beat.
    always @(negedge clk) begin
        beat_t e;
        if (rst) begin
            hold_chk = 0;
            expect_idle = 0;
        end else begin
            if (expect_idle) begin
                chk("post_last_busy", 32'(busy), 0);
                chk("post_last_valid", 32'(out_valid), 0);
                expect_idle = 0;
            end
            if (hold_chk) begin
                chk("hold_data", 32'(out_data), 32'(prev.data));
                chk("hold_chan", 32'(out_chan), 32'(prev.chan));
                chk("hold_last", 32'(out_last), 32'(prev.last));
            end
            hold_chk = out_valid && !out_ready;
            prev.data = out_data;
            prev.chan = out_chan;
            prev.last = out_last;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_beat", 32'(out_chan), 32'hFFFF);
                end else begin
                    e = sb.pop_front();
                    chk("beat_data", 32'(out_data), 32'(e.data));
                    chk("beat_chan", 32'(out_chan), 32'(e.chan));
                    chk("beat_last", 32'(out_last), 32'(e.last));
                    if (e.last) expect_idle = 1;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NUM_CH*WIDTH-1:0] base;
        for (int k = 0; k < NUM_CH; k++) base[k*WIDTH +: WIDTH] = WIDTH'(12'h101 + k);
        rst = 1'b1;
        mode = 1'b0;
        start = 1'b0;
        sel = '0;
        out_ready = 1'b1;
        mask_m = '1;
        din = base;
        tick();
        tick();
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_overrun", 32'(overrun), 0);
        chk("rst_data", 32'(out_data), 0);
        chk("rst_chan", 32'(out_chan), 0);
        chk("rst_last", 32'(out_last), 0);
        rst = 1'b0;
        tick();

        run_direct(0);
        run_direct(1);

        din = base;
        run_scan(0, 0, 0);
        din = base;
        run_scan(0, 1, 1);
        din = base;
        run_scan(1, 1, 0);

        // Reset while beat 3 is on the output.
        din = base;
        push_scan();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("midrst_valid", 32'(out_valid), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_overrun", 32'(overrun), 0);
        chk("midrst_data", 32'(out_data), 0);
        chk("midrst_last", 32'(out_last), 0);
        rst = 1'b0;
        sb.delete();
        exp_overrun = 1'b0;
        tick();
        run_scan(0, 0, 0);

`ifdef CH_MASK_EN
        mask_m = 6'b100101;
        run_scan(0, 0, 0);
        mask_m = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("zmask_busy", 32'(busy), 0);
        chk("zmask_valid", 32'(out_valid), 0);
        tick();
        chk("zmask_busy2", 32'(busy), 0);
        chk("zmask_overrun", 32'(overrun), 32'(exp_overrun));
`endif

        for (int i = 0; i < 12; i++) begin
            din = rand_din();
`ifdef CH_MASK_EN
            mask_m = NUM_CH'($urandom_range(1, (1 << NUM_CH) - 1));
`endif
            run_scan(($urandom_range(0, 3) == 0), 1'b1, 1'($urandom_range(0, 1)));
        end
        mask_m = '1;
        din = rand_din();
        run_direct(1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
